dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and the address range check for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when addr maps onto one of depth_words words starting at base.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input logic [WORD_W-1:0] base,
                                         input int unsigned       depth_words);
    logic [WORD_W-1:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 2) < WORD_W'(depth_words));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Read returns the pre-write word; only loads ever look at rdata.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store data-memory responder with programmable wait states.
// Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned / word-crossing byte enables as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // a response transfers with rsp_valid && rsp_ready, and rsp_* stay frozen until then.

  localparam int AW = $clog2(DEPTH_WORDS);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              hold_we, err_q;
  logic [WORD_W-1:0] hold_addr, hold_wdata;
  logic [BE_W-1:0]   hold_be;
  logic              req_fire, acc_en;
  logic              a_we, a_err, a_misalign;
  logic [WORD_W-1:0] a_addr, a_wdata;
  logic [BE_W-1:0]   a_be;
  logic [AW-1:0]     a_idx;
  logic [WORD_W-1:0] arr_rdata;

  assign req_fire = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter holds the remaining wait states; the edge that sees zero enters RESP.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_be    <= '0;
    end else if (req_fire) begin
      hold_we    <= req_we;
      hold_addr  <= req_addr;
      hold_wdata <= req_wdata;
      hold_be    <= req_be;
    end
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live request fields are used while still in IDLE.
  assign a_we    = (state == IDLE) ? req_we    : hold_we;
  assign a_addr  = (state == IDLE) ? req_addr  : hold_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : hold_wdata;
  assign a_be    = (state == IDLE) ? req_be    : hold_be;
  assign a_idx   = AW'((a_addr - BASE_ADDR) >> 2);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [2*BE_W-1:0] be_shift;
  assign be_shift   = {{BE_W{1'b0}}, a_be} << a_addr[1:0];
  assign a_misalign = ((a_addr[1:0] != 2'b00) && ($countones(a_be) > 1)) ||
                      (be_shift[2*BE_W-1:BE_W] != '0);
`else
  assign a_misalign = 1'b0;
`endif

  assign a_err  = !addr_in_range(a_addr, BASE_ADDR, DEPTH_WORDS) || a_misalign;
  assign acc_en = (state != RESP) && (state_nxt == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         err_q <= 1'b0;
    else if (acc_en) err_q <= a_err;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (acc_en),
    .we   (a_we && !a_err),
    .be   (a_be),
    .addr (a_idx),
    .wdata(a_wdata),
    .rdata(arr_rdata)
  );

  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = ((state == RESP) && !hold_we && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with default parameters (1024 words, 2 wait states, base 0).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles the inputs after acceptance, returns the response
  // and the number of edges from acceptance until rsp_valid was seen.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom_range(0, 15));
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout addr=%h rsp_valid=%b required 1", addr, rsp_valid);
    end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", d); end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, d, e, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", e); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, d, e, lat);
    do_req(1'b0, 32'h10, 32'h0, 4'b0001, d, e, lat);
    checks++; if (d !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_write got %h exp deadbeaa", d); end
  endtask

  task automatic test_be_zero();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h10, 32'h55555555, 4'b0000, d, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err got %b exp 0", e); end
    do_req(1'b0, 32'h10, 32'h0, 4'hF, d, e, lat);
    checks++; if (d !== 32'hDEADBEAA) begin errors++; $display("FAIL be0_data got %h exp deadbeaa", d); end
  endtask

  task automatic test_stall();
    int n;
    req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEADBEAA) begin errors++; $display("FAIL stall_rdata cyc %0d got %h exp deadbeaa", i, rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL stall_err cyc %0d got %b exp 0", i, rsp_err); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cyc %0d got %b exp 0", i, req_ready); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_xfer_valid got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_xfer_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_range();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h0, 32'h12345678, 4'hF, d, e, lat);
    do_req(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, d, e, lat);
    do_req(1'b0, 32'hFFC, 32'h0, 4'hF, d, e, lat);
    checks++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL last_word got %h err %b exp cafef00d err 0", d, e); end
    do_req(1'b0, 32'h1000, 32'h0, 4'hF, d, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b exp 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", d); end
    do_req(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, d, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b exp 1", e); end
    do_req(1'b0, 32'h0, 32'h0, 4'hF, d, e, lat);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL oor_word0 got %h exp 12345678", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat;
    do_req(1'b1, 32'h20, 32'h11111111, 4'hF, d, e, lat);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", rsp_valid); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got %b exp 1", req_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp got %b exp 0", rsp_valid); end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, d, e, lat);
    checks++; if (d !== 32'h11111111) begin errors++; $display("FAIL midrst_data got %h exp 11111111", d); end
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic e; int lat;
    logic [31:0] exp_d; logic exp_e;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_e = 1'b1; exp_d = 32'h11111111;
`else
    exp_e = 1'b0; exp_d = 32'h1111BBCC;
`endif
    do_req(1'b1, 32'h22, 32'h0000BBCC, 4'b0011, d, e, lat);
    checks++; if (e !== exp_e) begin errors++; $display("FAIL misalign_err got %b exp %b", e, exp_e); end
    do_req(1'b0, 32'h20, 32'h0, 4'hF, d, e, lat);
    checks++; if (d !== exp_d) begin errors++; $display("FAIL misalign_data got %h exp %h", d, exp_d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_be_zero();
    test_stall();
    test_range();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
